// File: rtl/fp_cmp_pkg.sv
// Shared definitions for the pipelined floating-point compare unit:
// op encodings, operand classification and the canonical quiet NaN.
package fp_cmp_pkg;

    // Widest operand the helper functions can describe; callers slice down.
    localparam int unsigned FP_MAX_W = 128;

    typedef enum logic [2:0] {
        FP_EQ = 3'd0,
        FP_NE = 3'd1,
        FP_LT = 3'd2,
        FP_LE = 3'd3,
        FP_GT = 3'd4,
        FP_GE = 3'd5
    } fp_op_e;

    typedef struct packed {
        logic is_nan;
        logic is_zero;
    } fp_class_t;

    // Canonical qNaN: sign 0, exponent all ones, fraction MSB set, rest 0.
    function automatic logic [FP_MAX_W-1:0] fp_canon_nan(input int unsigned exp_w,
                                                         input int unsigned frac_w);
        logic [FP_MAX_W-1:0] one;
        one = FP_MAX_W'(1);
        return (((one << exp_w) - one) << frac_w) | (one << (frac_w - 1));
    endfunction

    // Classify an operand from its zero-extended exponent and fraction fields.
    function automatic fp_class_t fp_classify(input logic [FP_MAX_W-1:0] exp_f,
                                              input logic [FP_MAX_W-1:0] frac_f,
                                              input int unsigned exp_w);
        fp_class_t c;
        logic [FP_MAX_W-1:0] one;
        one       = FP_MAX_W'(1);
        c.is_nan  = (exp_f == ((one << exp_w) - one)) && (frac_f != '0);
        c.is_zero = (exp_f == '0) && (frac_f == '0);
        return c;
    endfunction

endpackage

// File: rtl/fp_cmp_stage.sv
// Generic valid/ready pipeline register; holds its payload while stalled.
module fp_cmp_stage #(
    parameter int unsigned PAYLOAD_W = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_data
);

    // Accept a new payload whenever the register is empty or being drained.
    always_comb begin
        in_ready = !out_valid | out_ready;
    end

    // Register valid and payload; payload only changes on an accepted transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/fp_compare_pipe.sv
// Two-stage floating-point compare: stage 1 decodes operand fields and the
// magnitude relation, stage 2 resolves the requested op plus min/max.
module fp_compare_pipe
    import fp_cmp_pkg::*;
#(
    parameter int unsigned  EXP_W  = 8,
    parameter int unsigned  FRAC_W = 23,
    parameter int unsigned  TAG_W  = 4,
    localparam int unsigned W      = 1 + EXP_W + FRAC_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic [2:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_result,
    output logic [W-1:0]     out_min,
    output logic [W-1:0]     out_max,
    output logic             out_unordered,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [W-1:0] QNAN = W'(fp_canon_nan(EXP_W, FRAC_W));

    typedef struct packed {
        logic             sign_a;
        logic             sign_b;
        logic             nan_a;
        logic             nan_b;
        logic             zero_both;
        logic             mag_gt;
        logic             mag_eq;
        logic [2:0]       op;
        logic [TAG_W-1:0] tag;
        logic [W-1:0]     a;
        logic [W-1:0]     b;
    } dec_t;

    typedef struct packed {
        logic             result;
        logic [W-1:0]     min_v;
        logic [W-1:0]     max_v;
        logic             unordered;
        logic             illegal;
        logic [TAG_W-1:0] tag;
    } res_t;

    dec_t      dec_d, dec_q;
    res_t      res_d, res_q;
    logic      dec_valid, res_ready;
    fp_class_t cls_a, cls_b;
    logic      eq, lt, gt, unordered;

    // Decode fields and the unsigned {exp, frac} relation of the operands.
    always_comb begin
        cls_a           = fp_classify(FP_MAX_W'(in_a[W-2:FRAC_W]), FP_MAX_W'(in_a[FRAC_W-1:0]), EXP_W);
        cls_b           = fp_classify(FP_MAX_W'(in_b[W-2:FRAC_W]), FP_MAX_W'(in_b[FRAC_W-1:0]), EXP_W);
        dec_d.sign_a    = in_a[W-1];
        dec_d.sign_b    = in_b[W-1];
        dec_d.nan_a     = cls_a.is_nan;
        dec_d.nan_b     = cls_b.is_nan;
        dec_d.zero_both = cls_a.is_zero & cls_b.is_zero;
        dec_d.mag_gt    = in_a[W-2:0] > in_b[W-2:0];
        dec_d.mag_eq    = in_a[W-2:0] == in_b[W-2:0];
        dec_d.op        = in_op;
        dec_d.tag       = in_tag;
        dec_d.a         = in_a;
        dec_d.b         = in_b;
    end

    fp_cmp_stage #(.PAYLOAD_W($bits(dec_t))) u_dec_stage (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (dec_d),
        .out_valid (dec_valid),
        .out_ready (res_ready),
        .out_data  (dec_q)
    );

    // Resolve ordering, apply the requested op and select min/max.
    always_comb begin
        unordered = dec_q.nan_a | dec_q.nan_b;
        eq        = dec_q.zero_both | ((dec_q.sign_a == dec_q.sign_b) & dec_q.mag_eq);
        if (dec_q.sign_a != dec_q.sign_b) begin
            lt = dec_q.sign_a & !dec_q.zero_both;
        end else if (!dec_q.sign_a) begin
            lt = !dec_q.mag_gt & !dec_q.mag_eq;
        end else begin
            lt = dec_q.mag_gt;
        end
        if (unordered) begin
            eq = 1'b0;
            lt = 1'b0;
        end
        gt = !lt & !eq & !unordered;

        res_d.unordered = unordered;
        res_d.tag       = dec_q.tag;
        res_d.illegal   = 1'b0;
        case (dec_q.op)
            FP_EQ:   res_d.result = eq;
            FP_NE:   res_d.result = !eq;
            FP_LT:   res_d.result = lt;
            FP_LE:   res_d.result = lt | eq;
            FP_GT:   res_d.result = gt;
            FP_GE:   res_d.result = gt | eq;
            default: begin
                res_d.result  = 1'b0;
                res_d.illegal = 1'b1;
            end
        endcase

        if (dec_q.nan_a & dec_q.nan_b) begin
            res_d.min_v = QNAN;
            res_d.max_v = QNAN;
        end else if (dec_q.nan_a) begin
            res_d.min_v = dec_q.b;
            res_d.max_v = dec_q.b;
        end else if (dec_q.nan_b) begin
            res_d.min_v = dec_q.a;
            res_d.max_v = dec_q.a;
        end else if (eq & dec_q.zero_both) begin
            // Signed zeros: min prefers -0, max prefers +0.
            res_d.min_v = {dec_q.sign_a | dec_q.sign_b, {(W-1){1'b0}}};
            res_d.max_v = {dec_q.sign_a & dec_q.sign_b, {(W-1){1'b0}}};
        end else if (eq) begin
            res_d.min_v = dec_q.a;
            res_d.max_v = dec_q.a;
        end else begin
            res_d.min_v = lt ? dec_q.a : dec_q.b;
            res_d.max_v = gt ? dec_q.a : dec_q.b;
        end
    end

    fp_cmp_stage #(.PAYLOAD_W($bits(res_t))) u_res_stage (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (dec_valid),
        .in_ready  (res_ready),
        .in_data   (res_d),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (res_q)
    );

    // Present the registered result.
    always_comb begin
        out_result    = res_q.result;
        out_min       = res_q.min_v;
        out_max       = res_q.max_v;
        out_unordered = res_q.unordered;
        out_illegal   = res_q.illegal;
        out_tag       = res_q.tag;
    end

endmodule
